// File: rtl/instr_encode_loader_if.sv
// Bus bundle between a boot host and instr_encode_loader: request fields,
// the request handshake, the instruction-memory write port and session status.
interface instr_encode_loader_if #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 9
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        mnem;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [CNT_W-1:0]  count;

    modport master (
        output start, base_addr, in_valid, mnem, rs, rt, rd, shamt, imm, target, last,
        input  in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, count
    );

    modport slave (
        input  start, base_addr, in_valid, mnem, rs, rt, rd, shamt, imm, target, last,
        output in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, count
    );
endinterface

// File: rtl/instr_encode_loader.sv
// Encodes symbolic MIPS instruction requests and writes them sequentially into
// instruction memory. Define NOP_PAD_EN to pad each session with NOPs to a 4-word boundary.
module instr_encode_loader #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 9
) (
    input  logic                  clk,
    input  logic                  clrn,
    instr_encode_loader_if.slave  bus
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ACCEPT = 3'd1;
    localparam logic [2:0] WRITE  = 3'd2;
`ifdef NOP_PAD_EN
    localparam logic [2:0] PAD    = 3'd3;
`endif
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]        state;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [CNT_W-1:0]  count;
    logic              busy;
    logic              err;
    logic              last_q;
    logic              legal;
    logic              imem_we;
    logic [31:0]       enc_word;

    assign legal = (bus.mnem < 5'd20);

    // Unused fields of each format are forced to zero here
    always_comb begin
        enc_word = 32'd0;
        case (bus.mnem)
            5'd0:  enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'd0, 6'b100000};
            5'd1:  enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'd0, 6'b100010};
            5'd2:  enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'd0, 6'b100100};
            5'd3:  enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'd0, 6'b100101};
            5'd4:  enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'd0, 6'b100110};
            5'd5:  enc_word = {6'b000000, 5'd0, bus.rt, bus.rd, bus.shamt, 6'b000000};
            5'd6:  enc_word = {6'b000000, 5'd0, bus.rt, bus.rd, bus.shamt, 6'b000010};
            5'd7:  enc_word = {6'b000000, 5'd0, bus.rt, bus.rd, bus.shamt, 6'b000011};
            5'd8:  enc_word = {6'b000000, bus.rs, 15'd0, 6'b001000};
            5'd9:  enc_word = {6'b001000, bus.rs, bus.rt, bus.imm};
            5'd10: enc_word = {6'b001100, bus.rs, bus.rt, bus.imm};
            5'd11: enc_word = {6'b001101, bus.rs, bus.rt, bus.imm};
            5'd12: enc_word = {6'b001110, bus.rs, bus.rt, bus.imm};
            5'd13: enc_word = {6'b100011, bus.rs, bus.rt, bus.imm};
            5'd14: enc_word = {6'b101011, bus.rs, bus.rt, bus.imm};
            5'd15: enc_word = {6'b000100, bus.rs, bus.rt, bus.imm};
            5'd16: enc_word = {6'b000101, bus.rs, bus.rt, bus.imm};
            5'd17: enc_word = {6'b001111, 5'd0, bus.rt, bus.imm};
            5'd18: enc_word = {6'b000010, bus.target};
            5'd19: enc_word = {6'b000011, bus.target};
            default: enc_word = 32'd0;
        endcase
    end

    // Session FSM; a write at the top address ends the session so wptr never wraps
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state      <= IDLE;
            wptr       <= '0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            count      <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        wptr  <= bus.base_addr;
                        count <= '0;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (bus.in_valid) begin
                        if (legal) begin
                            imem_wdata <= enc_word;
                            imem_addr  <= wptr;
                            last_q     <= bus.last;
                            state      <= WRITE;
                        end else begin
                            err <= 1'b1;
                            if (bus.last) begin
                                state <= DONE;
                            end
                        end
                    end
                end
                WRITE: begin
                    count <= count + CNT_W'(1);
                    if (wptr == {ADDR_W{1'b1}}) begin
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        wptr <= wptr + ADDR_W'(1);
                        if (last_q) begin
`ifdef NOP_PAD_EN
                            imem_addr  <= wptr + ADDR_W'(1);
                            imem_wdata <= 32'd0;
                            state      <= PAD;
`else
                            state <= DONE;
`endif
                        end else begin
                            state <= ACCEPT;
                        end
                    end
                end
`ifdef NOP_PAD_EN
                PAD: begin
                    if (wptr[1:0] == 2'b00) begin
                        state <= DONE;
                    end else begin
                        count <= count + CNT_W'(1);
                        if (wptr == {ADDR_W{1'b1}}) begin
                            err   <= 1'b1;
                            state <= DONE;
                        end else begin
                            wptr      <= wptr + ADDR_W'(1);
                            imem_addr <= wptr + ADDR_W'(1);
                        end
                    end
                end
`endif
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        imem_we = (state == WRITE);
`ifdef NOP_PAD_EN
        if (state == PAD && wptr[1:0] != 2'b00) begin
            imem_we = 1'b1;
        end
`endif
    end

    assign bus.in_ready   = (state == ACCEPT);
    assign bus.imem_we    = imem_we;
    assign bus.imem_addr  = imem_addr;
    assign bus.imem_wdata = imem_wdata;
    assign bus.busy       = busy;
    assign bus.done       = (state == DONE);
    assign bus.err        = err;
    assign bus.count      = count;

endmodule
